mem_access_ctrl: RTL

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl_pkg.sv | 24 ++
 rtl/mem_timeout_cnt.sv | 28 ++
 rtl/mem_access_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared CPU-side encodings for the memory access controller: CPU state codes,
// opcodes, fault codes and the controller's internal enums.
package mem_access_ctrl_pkg;

  localparam int STATE_LEN = 3;

  localparam logic [STATE_LEN-1:0] STATE_IF  = 3'd0;
  localparam logic [STATE_LEN-1:0] STATE_MEM = 3'd3;

  localparam logic [5:0] OP_LW = 6'h23;
  localparam logic [5:0] OP_SW = 6'h2B;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

  typedef enum logic [1:0] {FSM_IDLE, FSM_REQ, FSM_WAIT, FSM_DONE} fsm_e;
  typedef enum logic [1:0] {KIND_NONE, KIND_FETCH, KIND_LOAD, KIND_STORE} kind_e;

  function automatic logic word_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/mem_timeout_cnt.sv
// Wait-cycle counter: counts enabled cycles and flags the cycle that reaches limit.
module mem_timeout_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Extra bit keeps the compare safe when cnt_q sits at its maximum value.
  assign expired = enable && (({1'b0, cnt_q} + 1'b1) == {1'b0, limit});

endmodule

// File: rtl/mem_access_ctrl.sv
// Multi-cycle CPU memory access controller: fetch/load/store handshake with
// misalignment and timeout faults, stall generation and one-shot re-arm.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [STATE_LEN-1:0] state,
  input  logic [5:0]           opcode,
  input  logic [31:0]          pc,
  input  logic [31:0]          alu_addr,
  input  logic [31:0]          wdata,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_rdata,
  input  logic                 mem_ack,
  output logic [31:0]          ir,
  output logic [31:0]          mdr,
  output logic                 stall,
  output logic                 err,
  output logic [1:0]           err_code
);

  fsm_e                 fsm_q;
  kind_e                kind_q, last_kind_q, kind_d;
  logic                 armed_q;
  logic [STATE_LEN-1:0] last_state_q;
  logic                 mem_req_q, mem_we_q, err_q;
  logic [31:0]          mem_addr_q, mem_wdata_q, ir_q, mdr_q;
  logic [1:0]           err_code_q;
  logic [31:0]          addr_d;
  logic                 want_d, blocked_d, misalign_d, start_d;
  logic                 cnt_clear, cnt_enable, expired;

  always_comb begin
    kind_d = KIND_NONE;
    if (state == STATE_IF) begin
      kind_d = KIND_FETCH;
    end else if (state == STATE_MEM && opcode == OP_LW) begin
      kind_d = KIND_LOAD;
    end else if (state == STATE_MEM && opcode == OP_SW) begin
      kind_d = KIND_STORE;
    end
  end

  assign addr_d     = (kind_d == KIND_FETCH) ? pc : alu_addr;
  // After an access (or fault) the same state/kind must change before another start.
  assign blocked_d  = !armed_q && state == last_state_q && kind_d == last_kind_q;
  assign want_d     = fsm_q == FSM_IDLE && kind_d != KIND_NONE && !blocked_d;
  assign misalign_d = want_d && !word_aligned(addr_d);
  assign start_d    = want_d && !misalign_d;
  assign stall      = start_d || fsm_q == FSM_REQ || fsm_q == FSM_WAIT;

  assign cnt_clear  = fsm_q != FSM_WAIT;
  assign cnt_enable = fsm_q == FSM_WAIT && !mem_ack;

  mem_timeout_cnt #(.W(8)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (cnt_clear),
    .enable  (cnt_enable),
    .limit   (8'(TIMEOUT)),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q        <= FSM_IDLE;
      kind_q       <= KIND_NONE;
      last_kind_q  <= KIND_NONE;
      last_state_q <= '0;
      armed_q      <= 1'b1;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      ir_q         <= '0;
      mdr_q        <= '0;
      err_q        <= 1'b0;
      err_code_q   <= ERR_NONE;
    end else begin
      case (fsm_q)
        FSM_IDLE: begin
          if (!armed_q && (state != last_state_q || kind_d != last_kind_q)) begin
            armed_q <= 1'b1;
          end
          if (start_d) begin
            fsm_q        <= FSM_REQ;
            kind_q       <= kind_d;
            mem_req_q    <= 1'b1;
            mem_we_q     <= kind_d == KIND_STORE;
            mem_addr_q   <= addr_d;
            mem_wdata_q  <= wdata;
            last_state_q <= state;
            last_kind_q  <= kind_d;
            armed_q      <= 1'b0;
          end else if (misalign_d) begin
            err_q        <= 1'b1;
            if (!err_q) err_code_q <= ERR_MISALIGN;
            last_state_q <= state;
            last_kind_q  <= kind_d;
            armed_q      <= 1'b0;
          end
        end
        FSM_REQ, FSM_WAIT: begin
          if (mem_ack) begin
            fsm_q     <= FSM_DONE;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            if (kind_q == KIND_FETCH) ir_q  <= mem_rdata;
            if (kind_q == KIND_LOAD)  mdr_q <= mem_rdata;
          end else if (fsm_q == FSM_REQ) begin
            fsm_q <= FSM_WAIT;
          end else if (expired) begin
            fsm_q     <= FSM_IDLE;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            err_q     <= 1'b1;
            if (!err_q) err_code_q <= ERR_TIMEOUT;
          end
        end
        FSM_DONE: fsm_q <= FSM_IDLE;
        default:  fsm_q <= FSM_IDLE;
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign ir        = ir_q;
  assign mdr       = mdr_q;
  assign err       = err_q;
  assign err_code  = err_code_q;

endmodule
